// File: rtl/cfi_pkg.sv
// Shared CFI types: the log entry format, dispatcher violation causes and FSM states.
package cfi_pkg;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] src_pc;
    logic [31:0] dst_pc;
  } cfi_log_t;

  typedef enum logic [1:0] {
    CFI_VIOL_NONE     = 2'd0,
    CFI_VIOL_MISMATCH = 2'd1,
    CFI_VIOL_TIMEOUT  = 2'd2
  } cfi_violation_e;

  typedef enum logic [1:0] {
    CFI_DISP_IDLE     = 2'd0,
    CFI_DISP_REQ      = 2'd1,
    CFI_DISP_WAIT_RSP = 2'd2,
    CFI_DISP_FAULT    = 2'd3
  } cfi_disp_state_e;

  localparam int unsigned CFI_TIMEOUT_DEFAULT = 1024;

  // A disabled timeout (0) still needs a legal one-bit timer vector.
  function automatic int unsigned cfi_timer_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/cfi_log_dispatcher.sv
// Drains the CFI log queue one entry at a time into the external checker and
// latches a sticky violation when the checker rejects a log or stops answering.
module cfi_log_dispatcher
  import cfi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = CFI_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 queue_empty_i,
  input  cfi_log_t             queue_data_i,
  output logic                 queue_pop_o,
  output logic                 checker_req_o,
  output cfi_log_t             checker_data_o,
  input  logic                 checker_gnt_i,
  input  logic                 checker_rsp_valid_i,
  input  logic                 checker_rsp_ok_i,
  input  logic                 clear_i,
  output logic                 cfi_violation_o,
  output cfi_violation_e       violation_cause_o,
  output cfi_log_t             violation_log_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] checked_cnt_o
);

  localparam int unsigned TimerW = cfi_timer_width(TIMEOUT_CYCLES);
  localparam logic [TimerW-1:0] TimerLast =
    TimerW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);

  cfi_disp_state_e      state_q, state_d;
  cfi_violation_e       cause_q, cause_d;
  cfi_log_t             log_q;
  logic [TimerW-1:0]    timer_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic rsp_pass;
  logic rsp_fail;
  logic timeout_hit;
  logic pop_ok;

  assign rsp_pass    = (state_q == CFI_DISP_WAIT_RSP) && checker_rsp_valid_i && checker_rsp_ok_i;
  assign rsp_fail    = (state_q == CFI_DISP_WAIT_RSP) && checker_rsp_valid_i && !checker_rsp_ok_i;
  // A response arriving in the expiry cycle takes priority over the timeout.
  assign timeout_hit = TimeoutEn && (state_q == CFI_DISP_WAIT_RSP) &&
                       !checker_rsp_valid_i && (timer_q == TimerLast);
  assign pop_ok      = !queue_empty_i && ((state_q == CFI_DISP_IDLE) || rsp_pass);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      CFI_DISP_IDLE: begin
        if (pop_ok) state_d = CFI_DISP_REQ;
      end
      CFI_DISP_REQ: begin
        if (checker_gnt_i) state_d = CFI_DISP_WAIT_RSP;
      end
      CFI_DISP_WAIT_RSP: begin
        if (rsp_pass) begin
          state_d = pop_ok ? CFI_DISP_REQ : CFI_DISP_IDLE;
        end else if (rsp_fail) begin
          state_d = CFI_DISP_FAULT;
          cause_d = CFI_VIOL_MISMATCH;
        end else if (timeout_hit) begin
          state_d = CFI_DISP_FAULT;
          cause_d = CFI_VIOL_TIMEOUT;
        end
      end
      CFI_DISP_FAULT: begin
        if (clear_i) begin
          state_d = CFI_DISP_IDLE;
          cause_d = CFI_VIOL_NONE;
        end
      end
      default: begin
        state_d = CFI_DISP_IDLE;
        cause_d = CFI_VIOL_NONE;
      end
    endcase
  end

  // The timer restarts on every grant, so it can never run past TimerLast.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CFI_DISP_IDLE;
      cause_q <= CFI_VIOL_NONE;
      log_q   <= '0;
      timer_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (pop_ok) log_q <= queue_data_i;
      if ((state_q == CFI_DISP_REQ) && checker_gnt_i) begin
        timer_q <= '0;
      end else if (TimeoutEn && (state_q == CFI_DISP_WAIT_RSP)) begin
        timer_q <= timer_q + 1'b1;
      end
      if (rsp_pass && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Gating with rst_ni keeps a non-empty queue from being drained while in reset.
  assign queue_pop_o       = pop_ok && rst_ni;
  assign checker_req_o     = (state_q == CFI_DISP_REQ);
  assign checker_data_o    = checker_req_o ? log_q : '0;
  assign cfi_violation_o   = (state_q == CFI_DISP_FAULT);
  assign violation_cause_o = cause_q;
  assign violation_log_o   = cfi_violation_o ? log_q : '0;
  assign busy_o            = (state_q != CFI_DISP_IDLE);
  assign checked_cnt_o     = cnt_q;

endmodule

// File: tb/tb_cfi_log_dispatcher.sv
// Directed bench for cfi_log_dispatcher: a FWFT queue model feeds the DUT and a
// scoreboard of enqueued logs is matched against what the checker port offers.
module tb_cfi_log_dispatcher;
  import cfi_pkg::*;

  localparam int CW = 3;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           queue_empty_i;
  cfi_log_t       queue_data_i;
  logic           queue_pop_o;
  logic           checker_req_o;
  cfi_log_t       checker_data_o;
  logic           checker_gnt_i = 1'b0;
  logic           checker_rsp_valid_i = 1'b0;
  logic           checker_rsp_ok_i = 1'b0;
  logic           clear_i = 1'b0;
  logic           cfi_violation_o;
  cfi_violation_e violation_cause_o;
  cfi_log_t       violation_log_o;
  logic           busy_o;
  logic [CW-1:0]  checked_cnt_o;

  always #5 clk_i = ~clk_i;

  cfi_log_dispatcher #(
    .TIMEOUT_CYCLES(8),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .queue_empty_i      (queue_empty_i),
    .queue_data_i       (queue_data_i),
    .queue_pop_o        (queue_pop_o),
    .checker_req_o      (checker_req_o),
    .checker_data_o     (checker_data_o),
    .checker_gnt_i      (checker_gnt_i),
    .checker_rsp_valid_i(checker_rsp_valid_i),
    .checker_rsp_ok_i   (checker_rsp_ok_i),
    .clear_i            (clear_i),
    .cfi_violation_o    (cfi_violation_o),
    .violation_cause_o  (violation_cause_o),
    .violation_log_o    (violation_log_o),
    .busy_o             (busy_o),
    .checked_cnt_o      (checked_cnt_o)
  );

  cfi_log_t mem [64];
  int       head = 0;
  int       tail = 0;
  int       cyc = 0;
  int       pop_cnt = 0;
  int       bad_pop = 0;
  int       pop_cyc [64];
  int       next_id = 1;
  int       vectors = 0;
  int       miscompares = 0;
  cfi_log_t exp_q [$];

  assign queue_empty_i = (head == tail);
  assign queue_data_i  = (head != tail) ? mem[head] : '0;

  // Queue model: consume the head on every pop and remember when it happened.
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (queue_pop_o) begin
      if (head == tail) bad_pop <= bad_pop + 1;
      else head <= head + 1;
      pop_cyc[pop_cnt] <= cyc;
      pop_cnt <= pop_cnt + 1;
    end
  end

  function automatic cfi_log_t mkLog(input int n);
    cfi_log_t l;
    l.kind   = 2'(n);
    l.src_pc = 32'h1000_0000 + 32'(n * 4);
    l.dst_pc = 32'h8000_0000 ^ 32'(n * 273);
    return l;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"},
                128'({queue_pop_o, checker_req_o, cfi_violation_o, violation_cause_o, busy_o, checked_cnt_o}),
                128'(0));
    checkOutput({tag, "_data"}, 128'(checker_data_o), 128'(0));
    checkOutput({tag, "_vlog"}, 128'(violation_log_o), 128'(0));
  endtask

  // Enqueue new logs and push the same values onto the scoreboard.
  task automatic applyStimulus(input int count);
    for (int i = 0; i < count; i++) begin
      cfi_log_t l;
      l = mkLog(next_id);
      next_id++;
      mem[tail] = l;
      exp_q.push_back(l);
      tail++;
    end
  endtask

  task automatic serveOne(input int gnt_wait, input int rsp_wait, input bit ok, input bit give_rsp);
    int       budget;
    cfi_log_t held;
    budget = 0;
    while (!checker_req_o && budget < 20) begin
      @(negedge clk_i);
      budget++;
    end
    if (!checker_req_o) begin
      checkOutput("req_wait", 128'(checker_req_o), 128'(1));
      return;
    end
    if (exp_q.size() > 0) checkOutput("req_data", 128'(checker_data_o), 128'(exp_q.pop_front()));
    else checkOutput("sb_underflow", 128'(exp_q.size()), 128'(1));
    held = checker_data_o;
    for (int i = 0; i < gnt_wait; i++) begin
      @(negedge clk_i);
      checkOutput("req_hold", 128'({checker_req_o, checker_data_o}), 128'({1'b1, held}));
    end
    checker_gnt_i = 1'b1;
    @(negedge clk_i);
    checker_gnt_i = 1'b0;
    for (int i = 0; i < rsp_wait; i++) @(negedge clk_i);
    if (give_rsp) begin
      checker_rsp_valid_i = 1'b1;
      checker_rsp_ok_i    = ok;
      @(negedge clk_i);
      checker_rsp_valid_i = 1'b0;
      checker_rsp_ok_i    = 1'b0;
    end
  endtask

  initial begin
    cfi_log_t b_log;
    cfi_log_t f_log;
    int       early;

    repeat (2) @(negedge clk_i);
    checkAllZero("reset");
    rst_ni = 1'b1;
    @(negedge clk_i);

    $display("[TB] single entry");
    applyStimulus(1);
    #1 checkOutput("t1_pop", 128'(queue_pop_o), 128'(1));
    serveOne(2, 2, 1'b1, 1'b1);
    checkOutput("t1_cnt", 128'(checked_cnt_o), 128'(1));
    checkOutput("t1_busy", 128'(busy_o), 128'(0));
    checkOutput("t1_pops", 128'(pop_cnt), 128'(1));

    $display("[TB] back-to-back");
    applyStimulus(3);
    for (int i = 0; i < 3; i++) serveOne(0, 1, 1'b1, 1'b1);
    checkOutput("t2_cnt", 128'(checked_cnt_o), 128'(4));
    checkOutput("t2_gap1", 128'(pop_cyc[2] - pop_cyc[1]), 128'(3));
    checkOutput("t2_gap2", 128'(pop_cyc[3] - pop_cyc[2]), 128'(3));
    checkOutput("t2_busy", 128'(busy_o), 128'(0));

    checker_rsp_valid_i = 1'b1;
    clear_i = 1'b1;
    @(negedge clk_i);
    checker_rsp_valid_i = 1'b0;
    clear_i = 1'b0;
    checkOutput("stale_rsp", 128'({cfi_violation_o, busy_o, checked_cnt_o}), 128'({1'b0, 1'b0, 3'd4}));

    $display("[TB] mismatch");
    b_log = mkLog(next_id);
    applyStimulus(3);
    serveOne(0, 0, 1'b0, 1'b1);
    #1 checkOutput("t3_flags", 128'({cfi_violation_o, violation_cause_o, checker_req_o, queue_pop_o}),
                   128'({1'b1, CFI_VIOL_MISMATCH, 1'b0, 1'b0}));
    checkOutput("t3_vlog", 128'(violation_log_o), 128'(b_log));
    repeat (3) @(negedge clk_i);
    checkOutput("t3_nopop", 128'(pop_cnt), 128'(5));
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    #1 checkOutput("t3_clear", 128'({queue_pop_o, cfi_violation_o, violation_cause_o, checked_cnt_o}),
                   128'({1'b1, 1'b0, CFI_VIOL_NONE, 3'd4}));
    checkOutput("t3_vlog0", 128'(violation_log_o), 128'(0));
    serveOne(0, 0, 1'b1, 1'b1);
    serveOne(0, 0, 1'b1, 1'b1);
    checkOutput("t3_cnt", 128'(checked_cnt_o), 128'(6));

    $display("[TB] timeout");
    f_log = mkLog(next_id);
    applyStimulus(1);
    serveOne(0, 0, 1'b1, 1'b0);
    early = 0;
    for (int k = 0; k < 8; k++) begin
      if (cfi_violation_o) early++;
      @(negedge clk_i);
    end
    checkOutput("t4_early", 128'(early), 128'(0));
    checkOutput("t4_fault", 128'({cfi_violation_o, violation_cause_o}), 128'({1'b1, CFI_VIOL_TIMEOUT}));
    checkOutput("t4_vlog", 128'(violation_log_o), 128'(f_log));
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;

    $display("[TB] response at expiry");
    applyStimulus(1);
    serveOne(0, 7, 1'b1, 1'b1);
    checkOutput("t5_nofault", 128'({cfi_violation_o, busy_o, checked_cnt_o}), 128'({1'b0, 1'b0, 3'd7}));
    applyStimulus(1);
    serveOne(0, 0, 1'b1, 1'b1);
    checkOutput("t5_sat", 128'(checked_cnt_o), 128'(7));

    $display("[TB] reset during wait");
    applyStimulus(3);
    serveOne(0, 2, 1'b1, 1'b0);
    rst_ni = 1'b0;
    #1 checkAllZero("t6_rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    checker_rsp_valid_i = 1'b1;
    checker_rsp_ok_i    = 1'b1;
    #1 checkOutput("t6_pop", 128'(queue_pop_o), 128'(1));
    @(negedge clk_i);
    checker_rsp_valid_i = 1'b0;
    checker_rsp_ok_i    = 1'b0;
    checkOutput("t6_after", 128'({checker_req_o, cfi_violation_o, checked_cnt_o}), 128'({1'b1, 1'b0, 3'd0}));
    serveOne(0, 0, 1'b1, 1'b1);
    serveOne(0, 0, 1'b1, 1'b1);
    checkOutput("t6_cnt", 128'(checked_cnt_o), 128'(2));

    repeat (2) @(negedge clk_i);
    checkOutput("sb_drained", 128'(exp_q.size()), 128'(0));
    checkOutput("queue_drained", 128'(tail - head), 128'(0));
    checkOutput("pop_empty", 128'(bad_pop), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
